// File: rtl/mips_exec_controller_pkg.sv
// Shared definitions for the mips execution controller: command opcodes,
// the bad-command response word and the controller state encoding.
package mips_exec_controller_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] CMD_RUN      = 3'd1;
  localparam logic [2:0] CMD_STEP     = 3'd2;
  localparam logic [2:0] CMD_PIPE_RST = 3'd3;
  localparam logic [2:0] CMD_RD_REG   = 3'd4;
  localparam logic [2:0] CMD_RD_MEM   = 3'd5;

  localparam logic [DATA_WIDTH-1:0] RSP_BAD_CMD = 32'hDEADC0DE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    PRST = 3'd3,
    RD   = 3'd4,
    RESP = 3'd5
  } state_t;

endpackage

// File: rtl/mips_exec_controller.sv
// Execution controller for the mips pipeline: accepts host commands, drives
// pipeline enable / soft reset, performs debug reads and returns one response
// word per command. All outputs are registered.
module mips_exec_controller
  import mips_exec_controller_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MAX_RUN    = 4096,
  parameter int RST_CYCLES = 4,
  parameter int MEM_AW     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd,
  input  logic [DATA_WIDTH-1:0] i_cmd_arg,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_pipe_en,
  output logic                  o_pipe_reset,
  input  logic                  i_halt,
  output logic [4:0]            o_dbg_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_reg_data,
  output logic [MEM_AW-1:0]     o_dbg_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_mem_data,
  output logic                  o_halted,
  output logic [CNT_W-1:0]      o_cycle_count
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [RST_W-1:0] rst_cnt;
  logic             rd_phase;
  logic             rd_mem;
  logic [CNT_W-1:0] cnt_next;
  logic             unused_arg;

  // Only the low address bits of the argument are meaningful.
  assign unused_arg = ^i_cmd_arg;

  // Saturating increment of the enabled-cycle counter.
  always_comb begin
    cnt_next = o_cycle_count;
    if (!(&o_cycle_count)) cnt_next = o_cycle_count + 1'b1;
  end

  // Controller FSM with registered outputs and inline counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      o_cmd_ready    <= 1'b1;
      o_rsp_valid    <= 1'b0;
      o_rsp_data     <= '0;
      o_pipe_en      <= 1'b0;
      o_pipe_reset   <= 1'b0;
      o_dbg_reg_addr <= '0;
      o_dbg_mem_addr <= '0;
      o_halted       <= 1'b0;
      o_cycle_count  <= '0;
      run_cnt        <= '0;
      rst_cnt        <= '0;
      rd_phase       <= 1'b0;
      rd_mem         <= 1'b0;
    end else begin
      if (o_pipe_en) o_cycle_count <= cnt_next;

      case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            case (i_cmd)
              CMD_RUN, CMD_STEP: begin
                if (o_halted) begin
                  o_rsp_data  <= DATA_WIDTH'(o_cycle_count);
                  o_rsp_valid <= 1'b1;
                  state       <= RESP;
                end else begin
                  o_pipe_en <= 1'b1;
                  run_cnt   <= '0;
                  state     <= (i_cmd == CMD_RUN) ? RUN : STEP;
                end
              end
              CMD_PIPE_RST: begin
                o_pipe_reset <= 1'b1;
                rst_cnt      <= '0;
                state        <= PRST;
              end
              CMD_RD_REG: begin
                o_dbg_reg_addr <= i_cmd_arg[4:0];
                rd_mem         <= 1'b0;
                rd_phase       <= 1'b0;
                state          <= RD;
              end
              CMD_RD_MEM: begin
                o_dbg_mem_addr <= i_cmd_arg[MEM_AW-1:0];
                rd_mem         <= 1'b1;
                rd_phase       <= 1'b0;
                state          <= RD;
              end
              default: begin
                o_rsp_data  <= RSP_BAD_CMD;
                o_rsp_valid <= 1'b1;
                state       <= RESP;
              end
            endcase
          end
        end

        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (i_halt || run_cnt == RUN_W'(MAX_RUN - 1)) begin
            if (i_halt) o_halted <= 1'b1;
            o_pipe_en   <= 1'b0;
            o_rsp_data  <= DATA_WIDTH'(cnt_next);
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end
        end

        STEP: begin
          if (i_halt) o_halted <= 1'b1;
          o_pipe_en   <= 1'b0;
          o_rsp_data  <= DATA_WIDTH'(cnt_next);
          o_rsp_valid <= 1'b1;
          state       <= RESP;
        end

        PRST: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            o_pipe_reset  <= 1'b0;
            o_cycle_count <= '0;
            o_halted      <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        // Address held for two cycles so the 1-cycle-latency memory has settled.
        RD: begin
          if (!rd_phase) begin
            rd_phase <= 1'b1;
          end else begin
            o_rsp_data     <= rd_mem ? i_dbg_mem_data : i_dbg_reg_data;
            o_dbg_reg_addr <= '0;
            o_dbg_mem_addr <= '0;
            o_rsp_valid    <= 1'b1;
            state          <= RESP;
          end
        end

        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          o_cmd_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_pipe_en   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
